vga_pixel_scanout: RTL and testbench

- Display-side reader for the 1-bit-per-pixel 640x480 frame buffer.
- Generates VGA horizontal/vertical timing and drives the frame buffer's pixel_x/pixel_y read port.
- Captures the returned pixel bit, which arrives one HCLK after the address.
- Emits registered hsync, vsync, data-enable and 12-bit RGB aligned to the captured pixel.

---
 rtl/vga_pixel_scanout.sv | 199 +++++++++++++++++++
 tb/tb_vga_pixel_scanout.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_scanout.sv
// vga_pixel_scanout
// Display-side reader for a 1-bit-per-pixel frame buffer. Generates VGA
// horizontal/vertical timing, drives the frame buffer read address, captures
// the returned pixel bit one pixel period later and emits registered
// hsync/vsync/de/rgb plus a one-HCLK frame_start pulse.
//
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces the frame buffer data with a 32x32 checkerboard in the active area.
module vga_pixel_scanout #(
  parameter int          CLK_DIV  = 2,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] FG_RGB   = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        HCLK,
  input  logic        HRESET,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic        pixel,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One spare code point so the sync-end compare constant never wraps.
  localparam int HW    = $clog2(H_TOTAL + 1);
  localparam int VW    = $clog2(V_TOTAL + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Column lies inside the visible area.
  function automatic logic h_visible(input logic [HW-1:0] h);
    return (h < H_ACT_END);
  endfunction

  // Row lies inside the visible area.
  function automatic logic v_visible(input logic [VW-1:0] v);
    return (v < V_ACT_END);
  endfunction

  // Active-low horizontal sync level for a column.
  function automatic logic h_sync_n(input logic [HW-1:0] h);
    return !((h >= H_SYNC_BEG) && (h < H_SYNC_END));
  endfunction

  // Active-low vertical sync level for a row.
  function automatic logic v_sync_n(input logic [VW-1:0] v);
    return !((v >= V_SYNC_BEG) && (v < V_SYNC_END));
  endfunction

  // Saturate the column address to 0 outside the visible area so the frame
  // buffer index never leaves the 640x480 window.
  function automatic logic [9:0] clamp_x(input logic [HW-1:0] h);
    return h_visible(h) ? 10'(h) : 10'd0;
  endfunction

  // Saturate the row address to 0 outside the visible area.
  function automatic logic [8:0] clamp_y(input logic [VW-1:0] v);
    return v_visible(v) ? 9'(v) : 9'd0;
  endfunction

  // Map a pixel bit to a colour; blanking is always black.
  function automatic logic [11:0] pick_rgb(input logic vis, input logic bit_on);
    if (!vis) return 12'h000;
    return bit_on ? FG_RGB : BG_RGB;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;

  logic             vld_p0;
  logic             hs_p0;
  logic             vs_p0;
  logic             first_p0;

  logic             vld_p1;
  logic             hs_p1;
  logic             vs_p1;
  logic             first_p1;

  logic             src_bit;

  assign pix_en = (div_cnt == DIV_LAST);

  // Pixel-rate divider: pix_en fires on the last HCLK of every pixel period.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  // Raster counters; the row advances when the column wraps.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // ---- stage p0: timing decode straight from the counters ----
  assign vld_p0   = h_visible(h_cnt) && v_visible(v_cnt);
  assign hs_p0    = h_sync_n(h_cnt);
  assign vs_p0    = v_sync_n(v_cnt);
  assign first_p0 = (h_cnt == '0) && (v_cnt == '0);

  // ---- stage p1: frame buffer address and first delay of the timing flags ----
  // Address register; the frame buffer answers before the next pix_en.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pix_en) begin
      pixel_x <= clamp_x(h_cnt);
      pixel_y <= clamp_y(v_cnt);
    end
  end

  // Timing flags travel alongside the address so they meet the returned pixel.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      first_p1 <= 1'b0;
    end else if (pix_en) begin
      vld_p1   <= vld_p0;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      first_p1 <= first_p0;
    end
  end

  // Colour source: frame buffer bit, or the checkerboard when test_mode is set.
  // The address register still holds the coordinates of the pixel being
  // presented, so its bit 5 selects the 32x32 block.
`ifdef VGA_TEST_PATTERN_EN
  assign src_bit = test_mode ? (pixel_x[5] ^ pixel_y[5]) : pixel;
`else
  assign src_bit = pixel;
`endif

  // ---- stage p2: registered video outputs ----
  // Video outputs; pixel is sampled on the same pix_en edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= 12'h000;
    end else if (pix_en) begin
      de    <= vld_p1;
      hsync <= hs_p1;
      vsync <= vs_p1;
      rgb   <= pick_rgb(vld_p1, src_bit);
    end
  end

  // frame_start lasts a single HCLK even when a pixel spans several HCLKs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) frame_start <= 1'b0;
    else        frame_start <= pix_en & first_p1;
  end

endmodule

// File: tb/tb_vga_pixel_scanout.sv
// Testbench for vga_pixel_scanout: three small-geometry instances at
// CLK_DIV 1/2/4 and one default-geometry instance, each fed by its own
// frame buffer read model, checked cycle by cycle against a raster model.
module tb_vga_pixel_scanout;

  localparam int SHA = 40, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 36, SVF = 2, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;
  localparam int DHA = 640, DHF = 16, DHS = 96, DHT = 800;
  localparam int DVA = 480, DVF = 10, DVS = 2,  DVT = 525;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic        fs;
  } vo_t;

  int dv  [4] = '{1, 2, 4, 2};
  int geo [4] = '{0, 0, 0, 1};

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic tm_sig = 1'b0;

  logic pix_a, pix_b, pix_c, pix_d;
  logic [9:0] px_a, px_b, px_c, px_d;
  logic [8:0] py_a, py_b, py_c, py_d;
  logic hs_a, hs_b, hs_c, hs_d, vs_a, vs_b, vs_c, vs_d;
  logic de_a, de_b, de_c, de_d, fs_a, fs_b, fs_c, fs_d;
  logic [11:0] rgb_a, rgb_b, rgb_c, rgb_d;

  bit fb [0:640*480-1];

  int total = 0;
  int bad = 0;

  int st_derise[4], st_defall[4], st_hf1[4], st_hf2[4], st_hr1[4];
  int st_vf1[4], st_vf2[4], st_vr1[4], st_fs[4], st_fff[4], st_maxx[4], st_maxy[4];

  always #5 HCLK = ~HCLK;

  vga_pixel_scanout #(.CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_a (
    .HCLK(HCLK), .HRESET(HRESET),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_sig),
`endif
    .pixel(pix_a), .pixel_x(px_a), .pixel_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .rgb(rgb_a), .frame_start(fs_a));

  vga_pixel_scanout #(.CLK_DIV(2), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_b (
    .HCLK(HCLK), .HRESET(HRESET),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_sig),
`endif
    .pixel(pix_b), .pixel_x(px_b), .pixel_y(py_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .rgb(rgb_b), .frame_start(fs_b));

  vga_pixel_scanout #(.CLK_DIV(4), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_c (
    .HCLK(HCLK), .HRESET(HRESET),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_sig),
`endif
    .pixel(pix_c), .pixel_x(px_c), .pixel_y(py_c), .hsync(hs_c), .vsync(vs_c),
    .de(de_c), .rgb(rgb_c), .frame_start(fs_c));

  vga_pixel_scanout u_d (
    .HCLK(HCLK), .HRESET(HRESET),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_sig),
`endif
    .pixel(pix_d), .pixel_x(px_d), .pixel_y(py_d), .hsync(hs_d), .vsync(vs_d),
    .de(de_d), .rgb(rgb_d), .frame_start(fs_d));

  // Frame buffer read port: data for the current address is presented half
  // an HCLK after it changes, i.e. within one HCLK.
  always @(negedge HCLK) begin
    pix_a <= fb[int'(py_a) * 640 + int'(px_a)];
    pix_b <= fb[int'(py_b) * 640 + int'(px_b)];
    pix_c <= fb[int'(py_c) * 640 + int'(px_c)];
    pix_d <= fb[int'(py_d) * 640 + int'(px_d)];
  end

  function automatic vo_t reset_vo();
    vo_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  function automatic vo_t obs_of(input int g);
    vo_t o;
    o = '0;
    case (g)
      0: begin o.x = px_a; o.y = py_a; o.hs = hs_a; o.vs = vs_a; o.de = de_a; o.rgb = rgb_a; o.fs = fs_a; end
      1: begin o.x = px_b; o.y = py_b; o.hs = hs_b; o.vs = vs_b; o.de = de_b; o.rgb = rgb_b; o.fs = fs_b; end
      2: begin o.x = px_c; o.y = py_c; o.hs = hs_c; o.vs = vs_c; o.de = de_c; o.rgb = rgb_c; o.fs = fs_c; end
      default: begin o.x = px_d; o.y = py_d; o.hs = hs_d; o.vs = vs_d; o.de = de_d; o.rgb = rgb_d; o.fs = fs_d; end
    endcase
    return o;
  endfunction

  // Raster model: k = HCLK edges since reset release. Pixel period p has
  // completed after edge p*d; the address shows raster position p-1, the
  // video outputs show raster position p-2.
  function automatic vo_t model(input int d, input int gsel, input int k, input bit tm);
    vo_t e;
    int p, pos, h, v, ha, hf, hsw, va, vf, vsw, ht, vt;
    if (gsel == 0) begin
      ha = SHA; hf = SHF; hsw = SHS; ht = SHT; va = SVA; vf = SVF; vsw = SVS; vt = SVT;
    end else begin
      ha = DHA; hf = DHF; hsw = DHS; ht = DHT; va = DVA; vf = DVF; vsw = DVS; vt = DVT;
    end
    e = reset_vo();
    p = k / d;
    if (p >= 1) begin
      pos = p - 1;
      h = pos % ht;
      v = (pos / ht) % vt;
      e.x = (h < ha) ? 10'(h) : 10'd0;
      e.y = (v < va) ? 9'(v) : 9'd0;
    end
    if (p >= 2) begin
      pos = p - 2;
      h = pos % ht;
      v = (pos / ht) % vt;
      e.de = (h < ha) && (v < va);
      e.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
      e.vs = !((v >= va + vf) && (v < va + vf + vsw));
      if (e.de) begin
        if (tm) e.rgb = (((h / 32) + (v / 32)) % 2 == 1) ? FG : BG;
        else    e.rgb = fb[v * 640 + h] ? FG : BG;
      end
      e.fs = (k % d == 0) && (pos % (ht * vt) == 0);
    end
    return e;
  endfunction

  task automatic do_reset();
    @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 640 * 480; i++) fb[i] = (($urandom() & 32'd1) != 0);
  endtask

  // Runs ncyc HCLKs after a release, comparing instances in gmask against the
  // model every cycle and gathering edge/count statistics for all instances.
  task automatic test_scan(input int ncyc, input logic [3:0] gmask, input string tag, input bit tm);
    vo_t o, e;
    vo_t prev [4];
    for (int g = 0; g < 4; g++) begin
      prev[g] = reset_vo();
      st_derise[g] = -1; st_defall[g] = -1; st_hf1[g] = -1; st_hf2[g] = -1; st_hr1[g] = -1;
      st_vf1[g] = -1; st_vf2[g] = -1; st_vr1[g] = -1;
      st_fs[g] = 0; st_fff[g] = 0; st_maxx[g] = 0; st_maxy[g] = 0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge HCLK);
      #1;
      for (int g = 0; g < 4; g++) begin
        o = obs_of(g);
        if (o.de && !prev[g].de && st_derise[g] < 0) st_derise[g] = k;
        if (!o.de && prev[g].de && st_defall[g] < 0) st_defall[g] = k;
        if (!o.hs && prev[g].hs) begin
          if (st_hf1[g] < 0) st_hf1[g] = k; else if (st_hf2[g] < 0) st_hf2[g] = k;
        end
        if (o.hs && !prev[g].hs && st_hr1[g] < 0) st_hr1[g] = k;
        if (!o.vs && prev[g].vs) begin
          if (st_vf1[g] < 0) st_vf1[g] = k; else if (st_vf2[g] < 0) st_vf2[g] = k;
        end
        if (o.vs && !prev[g].vs && st_vr1[g] < 0) st_vr1[g] = k;
        if (o.fs === 1'b1) st_fs[g]++;
        if (o.rgb === 12'hFFF) st_fff[g]++;
        if (int'(o.x) > st_maxx[g]) st_maxx[g] = int'(o.x);
        if (int'(o.y) > st_maxy[g]) st_maxy[g] = int'(o.y);
        prev[g] = o;
        if (gmask[g]) begin
          e = model(dv[g], geo[g], k, tm);
          total++; if (o.x !== e.x) begin bad++; $display("FAIL %s pixel_x inst%0d k=%0d got %0d want %0d", tag, g, k, o.x, e.x); end
          total++; if (o.y !== e.y) begin bad++; $display("FAIL %s pixel_y inst%0d k=%0d got %0d want %0d", tag, g, k, o.y, e.y); end
          total++; if (o.hs !== e.hs) begin bad++; $display("FAIL %s hsync inst%0d k=%0d got %b want %b", tag, g, k, o.hs, e.hs); end
          total++; if (o.vs !== e.vs) begin bad++; $display("FAIL %s vsync inst%0d k=%0d got %b want %b", tag, g, k, o.vs, e.vs); end
          total++; if (o.de !== e.de) begin bad++; $display("FAIL %s de inst%0d k=%0d got %b want %b", tag, g, k, o.de, e.de); end
          total++; if (o.rgb !== e.rgb) begin bad++; $display("FAIL %s rgb inst%0d k=%0d got %h want %h", tag, g, k, o.rgb, e.rgb); end
          total++; if (o.fs !== e.fs) begin bad++; $display("FAIL %s frame_start inst%0d k=%0d got %b want %b", tag, g, k, o.fs, e.fs); end
        end
      end
    end
  endtask

  task automatic test_reset();
    vo_t o, e;
    @(posedge HCLK);
    #1;
    e = reset_vo();
    for (int g = 0; g < 4; g++) begin
      o = obs_of(g);
      total++; if (o !== e) begin bad++; $display("FAIL reset_state inst%0d got %h want %h", g, o, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    vo_t o, e;
    int ncheck;
    ncheck = 0;
    // let the instances reach the visible area first
    do_reset();
    repeat (20 * SHT + 7) @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    e = reset_vo();
    for (int g = 0; g < 4; g++) begin
      o = obs_of(g);
      total++; if (o !== e) begin bad++; $display("FAIL reset_mid inst%0d got %h want %h", g, o, e); end
    end
  endtask

  task automatic test_random_scan();
    int ncyc, fs_want, m;
    fill_random();
    do_reset();
    ncyc = 2 * SFR * 4 + 16;
    test_scan(ncyc, 4'b0111, "random", 1'b0);
    fs_want = 0;
    m = 0;
    while ((m * SFR + 2) * 2 <= ncyc) begin fs_want++; m++; end
    total++; if (st_vf2[1] - st_vf1[1] !== SFR * 2) begin bad++; $display("FAIL vsync_period got %0d want %0d", st_vf2[1] - st_vf1[1], SFR * 2); end
    total++; if (st_vr1[1] - st_vf1[1] !== SVS * SHT * 2) begin bad++; $display("FAIL vsync_low got %0d want %0d", st_vr1[1] - st_vf1[1], SVS * SHT * 2); end
    total++; if (st_vf1[1] - st_derise[1] !== (SVA + SVF) * SHT * 2) begin bad++; $display("FAIL vsync_start got %0d want %0d", st_vf1[1] - st_derise[1], (SVA + SVF) * SHT * 2); end
    total++; if (st_fs[1] !== fs_want) begin bad++; $display("FAIL frame_start_count got %0d want %0d", st_fs[1], fs_want); end
    total++; if (st_maxx[0] !== SHA - 1) begin bad++; $display("FAIL max_pixel_x got %0d want %0d", st_maxx[0], SHA - 1); end
    total++; if (st_maxy[0] !== SVA - 1) begin bad++; $display("FAIL max_pixel_y got %0d want %0d", st_maxy[0], SVA - 1); end
    total++; if (st_hf2[0] - st_hf1[0] !== SHT) begin bad++; $display("FAIL hsync_period_div1 got %0d want %0d", st_hf2[0] - st_hf1[0], SHT); end
  endtask

  task automatic test_single_pixel();
    int ncyc, tgt, want, m;
    for (int i = 0; i < 640 * 480; i++) fb[i] = 1'b0;
    fb[20 * 640 + 10] = 1'b1;
    do_reset();
    ncyc = SFR * 4 + 16;
    test_scan(ncyc, 4'b0111, "single", 1'b0);
    tgt = 20 * SHT + 10;
    for (int g = 0; g < 3; g++) begin
      want = 0;
      m = 0;
      while ((m * SFR + tgt + 2) * dv[g] + dv[g] - 1 <= ncyc) begin want += dv[g]; m++; end
      total++; if (st_fff[g] !== want) begin bad++; $display("FAIL single_pixel_cycles inst%0d got %0d want %0d", g, st_fff[g], want); end
    end
  endtask

  task automatic test_line_timing();
    fill_random();
    do_reset();
    test_scan(3400, 4'b1000, "line", 1'b0);
    total++; if (st_hf2[3] - st_hf1[3] !== 1600) begin bad++; $display("FAIL hsync_period got %0d want 1600", st_hf2[3] - st_hf1[3]); end
    total++; if (st_hr1[3] - st_hf1[3] !== 192) begin bad++; $display("FAIL hsync_low got %0d want 192", st_hr1[3] - st_hf1[3]); end
    total++; if (st_defall[3] - st_derise[3] !== 1280) begin bad++; $display("FAIL de_high got %0d want 1280", st_defall[3] - st_derise[3]); end
    total++; if (st_hf1[3] - st_derise[3] !== 1312) begin bad++; $display("FAIL hsync_offset got %0d want 1312", st_hf1[3] - st_derise[3]); end
    total++; if (st_maxx[3] !== 639) begin bad++; $display("FAIL max_pixel_x_default got %0d want 639", st_maxx[3]); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_test_pattern();
    fill_random();
    tm_sig = 1'b1;
    do_reset();
    test_scan(SFR * 4 + 16, 4'b0111, "pattern", 1'b1);
    tm_sig = 1'b0;
    do_reset();
    test_scan(SFR * 2 + 16, 4'b0011, "pattern_off", 1'b0);
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_random_scan();
    test_reset_mid_frame();
    test_single_pixel();
    test_line_timing();
`ifdef VGA_TEST_PATTERN_EN
    test_test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
